// File: rtl/free_list_pkg.sv
// Shared sizing constants and types for the multi-port physical-tag free list.
package free_list_pkg;

    localparam int unsigned DATA_WIDTH = 6;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned PTR_WIDTH  = 5;
    localparam int unsigned ALLOC_W    = 2;
    localparam int unsigned REL_W      = 2;
    localparam int unsigned INIT_BASE  = 1;
    localparam int unsigned CNT_WIDTH  = $clog2(((ALLOC_W > REL_W) ? ALLOC_W : REL_W) + 1);

    // Pointers carry one wrap bit above the index so full and empty differ.
    typedef logic [PTR_WIDTH:0]   ptr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/lane_prefix_cnt.sv
// Per-lane exclusive prefix count of a valid vector, plus its total popcount.
module lane_prefix_cnt
    import free_list_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                 vld,
    output logic [N*$clog2(N+1)-1:0]     prefix,
    output logic [$clog2(N+1)-1:0]       total
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int k = 0; k < N; k++) begin
            prefix[k*CW +: CW] = acc;
            acc = acc + CW'(vld[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list_mport.sv
// Multi-port circular free list of physical register tags (rename allocates, retire releases).
// Define FREE_LIST_ROLLBACK_EN to add committed-pointer tracking and flush rollback.
module free_list_mport
    import free_list_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ALLOC_W-1:0]            alloc_req,
    output logic                          alloc_ready,
    output logic [ALLOC_W*DATA_WIDTH-1:0] alloc_data,
    input  logic [REL_W-1:0]              rel_vld,
    input  logic [REL_W*DATA_WIDTH-1:0]   rel_data,
    output logic                          rel_ready,
    output logic [PTR_WIDTH:0]            free_num,
    output logic                          empty,
    output logic                          full
`ifdef FREE_LIST_ROLLBACK_EN
    ,
    input  logic [$clog2(ALLOC_W+1)-1:0]  cmt_cnt,
    input  logic                          flush
`endif
);

    localparam int unsigned AW = $clog2(ALLOC_W + 1);
    localparam int unsigned RW = $clog2(REL_W + 1);

    logic [DATA_WIDTH-1:0] queue_q [DEPTH];
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    logic [ALLOC_W*AW-1:0] alloc_pre;
    logic [AW-1:0]         alloc_pop;
    logic [REL_W*RW-1:0]   rel_pre;
    logic [RW-1:0]         rel_pop;
    logic                  alloc_fire;
    logic                  rel_fire;
    logic [PTR_WIDTH-1:0]  rd_idx [ALLOC_W];
    logic [PTR_WIDTH-1:0]  wr_idx [REL_W];

    lane_prefix_cnt #(.N(ALLOC_W)) u_alloc_cnt (
        .vld    (alloc_req),
        .prefix (alloc_pre),
        .total  (alloc_pop)
    );

    lane_prefix_cnt #(.N(REL_W)) u_rel_cnt (
        .vld    (rel_vld),
        .prefix (rel_pre),
        .total  (rel_pop)
    );

    assign free_num    = wr_ptr_q - rd_ptr_q;
    assign empty       = (free_num == '0);
    assign full        = (free_num == ptr_t'(DEPTH));
    // Both ready flags look only at the pre-edge count: no same-cycle bypass.
    assign alloc_ready = (free_num >= ptr_t'(alloc_pop));
    assign rel_ready   = ((ptr_t'(DEPTH) - free_num) >= ptr_t'(REL_W));
    assign rel_fire    = rel_ready & (|rel_vld);

    // Requested lanes are packed: lane k takes the entry after all lower requesting lanes.
    always_comb begin
        alloc_data = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            rd_idx[k] = rd_ptr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(alloc_pre[k*AW +: AW]);
            alloc_data[k*DATA_WIDTH +: DATA_WIDTH] = queue_q[rd_idx[k]];
        end
        for (int k = 0; k < REL_W; k++) begin
            wr_idx[k] = wr_ptr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(rel_pre[k*RW +: RW]);
        end
    end

`ifdef FREE_LIST_ROLLBACK_EN
    ptr_t cmt_rd_ptr_q, cmt_rd_ptr_d;

    assign alloc_fire = alloc_ready & (|alloc_req) & ~flush;
`else
    assign alloc_fire = alloc_ready & (|alloc_req);
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (alloc_fire) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(alloc_pop);
        end
        if (rel_fire) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(rel_pop);
        end
`ifdef FREE_LIST_ROLLBACK_EN
        cmt_rd_ptr_d = cmt_rd_ptr_q + ptr_t'(cmt_cnt);
        // Uncommitted allocations return to the head of the list.
        if (flush) begin
            rd_ptr_d = cmt_rd_ptr_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                queue_q[i] <= DATA_WIDTH'(INIT_BASE + i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= ptr_t'(DEPTH);
`ifdef FREE_LIST_ROLLBACK_EN
            cmt_rd_ptr_q <= '0;
`endif
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef FREE_LIST_ROLLBACK_EN
            cmt_rd_ptr_q <= cmt_rd_ptr_d;
`endif
            for (int k = 0; k < REL_W; k++) begin
                if (rel_fire && rel_vld[k]) begin
                    queue_q[wr_idx[k]] <= rel_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(|rel_vld) || rel_ready)
                else $error("free_list_mport: release dropped while rel_ready low");
`ifdef FREE_LIST_ROLLBACK_EN
            assert ((rd_ptr_q - cmt_rd_ptr_q) <= ptr_t'(DEPTH))
                else $error("free_list_mport: committed pointer passed read pointer");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_free_list_mport.sv
// Randomised bench for free_list_mport against a tag-queue reference model.
module tb_free_list_mport;
    import free_list_pkg::*;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [ALLOC_W-1:0]            alloc_req;
    logic                          alloc_ready;
    logic [ALLOC_W*DATA_WIDTH-1:0] alloc_data;
    logic [REL_W-1:0]              rel_vld;
    logic [REL_W*DATA_WIDTH-1:0]   rel_data;
    logic                          rel_ready;
    logic [PTR_WIDTH:0]            free_num;
    logic                          empty;
    logic                          full;
`ifdef FREE_LIST_ROLLBACK_EN
    logic [1:0]                    cmt_cnt;
    logic                          flush;
`endif

    always #5 clk = ~clk;

    free_list_mport u_dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_data  (alloc_data),
        .rel_vld     (rel_vld),
        .rel_data    (rel_data),
        .rel_ready   (rel_ready),
        .free_num    (free_num),
        .empty       (empty),
        .full        (full)
`ifdef FREE_LIST_ROLLBACK_EN
        ,
        .cmt_cnt     (cmt_cnt),
        .flush       (flush)
`endif
    );

    int n_vec;
    int n_err;
    int model_q[$];   // free tags in allocation order
    int pending;      // allocated but not yet committed
    bit auto_cmt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        model_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) model_q.push_back(int'(INIT_BASE) + i);
        pending = 0;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        alloc_req = '0;
        rel_vld   = '0;
        rel_data  = '0;
`ifdef FREE_LIST_ROLLBACK_EN
        cmt_cnt   = '0;
        flush     = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle: drive, check combinational outputs mid-cycle, advance model and DUT.
    task automatic step(input logic [1:0] areq, input logic [1:0] rvld, input int t0, input int t1);
        int apop;
        int idx;
        int cmt;
        bit exp_a;
        bit exp_r;
        alloc_req = areq;
        rel_vld   = rvld;
        rel_data  = {DATA_WIDTH'(t1), DATA_WIDTH'(t0)};
        cmt       = auto_cmt ? pending : 0;
`ifdef FREE_LIST_ROLLBACK_EN
        cmt_cnt   = 2'(cmt);
        flush     = 1'b0;
`endif
        apop  = $countones(areq);
        exp_a = (apop <= model_q.size());
        exp_r = ((int'(DEPTH) - model_q.size()) >= int'(REL_W));
        @(negedge clk);
        check("free_num", 32'(free_num), model_q.size());
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("full", 32'(full), 32'(model_q.size() == int'(DEPTH)));
        check("alloc_ready", 32'(alloc_ready), 32'(exp_a));
        check("rel_ready", 32'(rel_ready), 32'(exp_r));
        if (exp_a) begin
            idx = 0;
            for (int k = 0; k < int'(ALLOC_W); k++) begin
                if (areq[k]) begin
                    check($sformatf("alloc_data[%0d]", k),
                          32'(alloc_data[k*DATA_WIDTH +: DATA_WIDTH]), model_q[idx]);
                    idx++;
                end
            end
        end
        pending -= cmt;
        if (exp_a && apop > 0) begin
            repeat (apop) void'(model_q.pop_front());
            pending += apop;
        end
        if (exp_r) begin
            if (rvld[0]) model_q.push_back(t0 % 64);
            if (rvld[1]) model_q.push_back(t1 % 64);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] areq;
        logic [1:0] rvld;
        n_vec    = 0;
        n_err    = 0;
        auto_cmt = 1'b1;

        // Reset state and first dual allocation: {2,1}, then 30 left.
        do_reset();
        step(2'b11, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);

        // Packing: lone lane 1 gets tag 1, then {3,2}; drain to 1 and test all-or-nothing.
        do_reset();
        step(2'b10, 2'b00, 0, 0);
        step(2'b11, 2'b00, 0, 0);
        repeat (14) step(2'b11, 2'b00, 0, 0);
        step(2'b11, 2'b00, 0, 0);
        step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);

        // Walk the write index to 31 so the pair {7,9} straddles the wrap.
        for (int i = 0; i < 15; i++) step(2'b00, 2'b11, 10 + 2 * i, 11 + 2 * i);
        step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b01, 50, 0);
        step(2'b00, 2'b11, 7, 9);
        repeat (16) step(2'b11, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);

        // Simultaneous alloc and release; then release into an empty list.
        do_reset();
        step(2'b11, 2'b00, 0, 0);
        step(2'b11, 2'b11, 20, 21);
        step(2'b00, 2'b00, 0, 0);
        repeat (15) step(2'b11, 2'b00, 0, 0);
        step(2'b11, 2'b11, 22, 23);
        step(2'b00, 2'b00, 0, 0);

`ifdef FREE_LIST_ROLLBACK_EN
        // Four tags out, one committed alongside the flush: tag 2 comes back first.
        do_reset();
        auto_cmt = 1'b0;
        step(2'b11, 2'b00, 0, 0);
        step(2'b11, 2'b00, 0, 0);
        alloc_req = 2'b11;
        rel_vld   = 2'b00;
        cmt_cnt   = 2'd1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cmt_cnt   = 2'd0;
        alloc_req = 2'b01;
        @(negedge clk);
        check("rollback free_num", 32'(free_num), 31);
        check("rollback alloc_data", 32'(alloc_data[DATA_WIDTH-1:0]), 2);
        auto_cmt = 1'b1;
`endif

        // Random traffic with occasional mid-run reset.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                areq = 2'($urandom);
                rvld = 2'($urandom);
                if ((int'(DEPTH) - model_q.size()) < int'(REL_W)) rvld = 2'b00;
                step(areq, rvld, int'($urandom_range(1, 63)), int'($urandom_range(1, 63)));
            end
        end
        step(2'b00, 2'b00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
